// File: rtl/demux_pkg.sv
// Shared types for the 1:2 streaming demultiplexer and its lane FIFOs.
package demux_pkg;

    typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

    localparam int unsigned DEMUX_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane FIFO for demux_2_stream.
// Occupancy is tracked as an EMPTY/PARTIAL/FULL state machine alongside the count.
module lane_fifo
    import demux_pkg::*;
#(
    parameter int unsigned data_width = 16,
    parameter int unsigned DEPTH      = DEMUX_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [data_width-1:0]        din,
    output logic                         full,
    input  logic                         pop,
    output logic [data_width-1:0]        dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [data_width-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_next;
    occ_e                  state;
    occ_e                  state_next;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (state == FULL);
    assign valid   = (state != EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;
    assign count   = count_q;
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count_q;
        state_next = state;
        case ({do_push, do_pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
        case (state)
            EMPTY:   if (do_push) state_next = PARTIAL;
            PARTIAL: begin
                if (do_push && !do_pop && count_q == CW'(DEPTH - 1))
                    state_next = FULL;
                else if (do_pop && !do_push && count_q == CW'(1))
                    state_next = EMPTY;
            end
            FULL:    if (do_pop) state_next = PARTIAL;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is deliberately left out of reset; dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/demux_2_stream.sv
// 1:2 streaming demultiplexer: each beat is steered by in_sel into one of two lane FIFOs.
module demux_2_stream
    import demux_pkg::*;
#(
    parameter int unsigned data_width = 16,
    parameter int unsigned DEPTH      = DEMUX_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         in_sel,
    input  logic [data_width-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out0_valid,
    output logic [data_width-1:0]        out0_data,
    input  logic                         out0_ready,
    output logic                         out1_valid,
    output logic [data_width-1:0]        out1_data,
    input  logic                         out1_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count0,
    output logic [$clog2(DEPTH+1)-1:0]   count1
);

    logic  full0;
    logic  full1;
    logic  push0;
    logic  push1;
    lane_e lane;

    assign lane = lane_e'(in_sel);

    // in_ready depends only on the selected lane's full flag, never on outN_ready.
    always_comb begin
        in_ready = 1'b0;
        case (lane)
            LANE0:   in_ready = ~full0;
            LANE1:   in_ready = ~full1;
            default: in_ready = 1'b0;
        endcase
    end

    assign push0 = in_valid & in_ready & (lane == LANE0);
    assign push1 = in_valid & in_ready & (lane == LANE1);

    lane_fifo #(
        .data_width (data_width),
        .DEPTH      (DEPTH)
    ) u_lane0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .din   (in_data),
        .full  (full0),
        .pop   (out0_ready),
        .dout  (out0_data),
        .valid (out0_valid),
        .count (count0)
    );

    lane_fifo #(
        .data_width (data_width),
        .DEPTH      (DEPTH)
    ) u_lane1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .din   (in_data),
        .full  (full1),
        .pop   (out1_ready),
        .dout  (out1_data),
        .valid (out1_valid),
        .count (count1)
    );

endmodule

// File: tb/tb_demux_2_stream.sv
// Randomized self-checking bench for demux_2_stream against a queue-based lane model.
module tb_demux_2_stream;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_sel;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out0_valid;
    logic [DW-1:0] out0_data;
    logic          out0_ready;
    logic          out1_valid;
    logic [DW-1:0] out1_data;
    logic          out1_ready;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] rx[$];

    int n_checks = 0;
    int n_pass   = 0;

    demux_2_stream #(
        .data_width (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
        check("out0_data",  32'(out0_data),  (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        check("count0",     32'(count0),     32'(q0.size()));
        check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
        check("out1_data",  32'(out1_data),  (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
        check("count1",     32'(count1),     32'(q1.size()));
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs after it.
    task automatic cycle(output bit accepted);
        bit exp_rdy, p0, p1;
        #1;
        exp_rdy = in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        accepted = in_valid && exp_rdy;
        p0 = out0_ready && (q0.size() != 0);
        p1 = out1_ready && (q1.size() != 0);
        if (p1) rx.push_back(out1_data);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (accepted) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        bit acc;
        int sent;
        int budget;

        // Reset with a producer already asserting valid
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h5A5A;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Fill lane 0
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111; cycle(acc);
        in_data = 16'h2222; cycle(acc);
        in_valid = 1'b0;
        check("fill_count0", 32'(count0), 32'd2);
        check("fill_head0", 32'(out0_data), 32'h1111);
        in_sel = 1'b0; #1; check("rdy_sel0_full", 32'(in_ready), 32'd0);
        in_sel = 1'b1; #1; check("rdy_sel1_free", 32'(in_ready), 32'd1);

        // Lane 1 accepts while lane 0 is full
        in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hAAAA; cycle(acc);
        in_valid = 1'b0;
        check("lane1_accept", 32'(acc), 32'd1);
        check("lane1_valid", 32'(out1_valid), 32'd1);
        check("lane0_untouched", 32'(count0), 32'd2);

        // Pop to one entry, then push and pop together
        out0_ready = 1'b1; out1_ready = 1'b1; cycle(acc);
        out1_ready = 1'b0;
        check("pop_count0", 32'(count0), 32'd1);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h3333; cycle(acc);
        check("pushpop_count0", 32'(count0), 32'd1);
        check("pushpop_head0", 32'(out0_data), 32'h3333);

        // Full lane refuses a push even while the sink pops
        out0_ready = 1'b0; in_data = 16'h4444; cycle(acc);
        check("refill_count0", 32'(count0), 32'd2);
        out0_ready = 1'b1; in_data = 16'h5555; cycle(acc);
        check("full_pop_no_push", 32'(acc), 32'd0);
        check("full_pop_count0", 32'(count0), 32'd1);
        check("full_pop_head0", 32'(out0_data), 32'h4444);
        in_valid = 1'b0; cycle(acc);
        out0_ready = 1'b0;

        // Stream ten beats to lane 1 under random back-pressure
        rx.delete();
        sent = 0; budget = 0;
        while ((sent < 10 || q1.size() != 0) && budget < 500) begin
            in_valid = (sent < 10); in_sel = 1'b1; in_data = DW'(sent + 1);
            out1_ready = 1'($urandom_range(0, 1));
            out0_ready = 1'($urandom_range(0, 1));
            cycle(acc);
            if (acc) sent++;
            budget++;
        end
        in_valid = 1'b0;
        check("stream_budget", 32'(budget < 500), 32'd1);
        check("stream_rx_count", 32'(rx.size()), 32'd10);
        for (int i = 0; i < rx.size(); i++) check("stream_order", 32'(rx[i]), 32'(i + 1));

        // Async reset in the middle of a stream
        out1_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1;
        in_data = 16'h00B1; cycle(acc);
        in_data = 16'h00B2; cycle(acc);
        check("pre_reset_count1", 32'(count1), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_count1", 32'(count1), 32'd0);
        check("async_valid1", 32'(out1_valid), 32'd0);
        check("async_data1", 32'(out1_data), 32'd0);
        q0.delete(); q1.delete();
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        cycle(acc);

        // Random traffic; producer holds a refused beat stable
        acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
            end
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
            cycle(acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
